vector_addsub_sequencer: RTL and testbench
==========================================

# vector_addsub_sequencer

Front-end stage for the fixed-point add/sub unit. Accepts one three-component (X, Y, Z) vector add or subtract request, issues the lanes one at a time to the scalar `FixedAddSub` unit, and collects the lane results. Presents the assembled vector result with a one-cycle done pulse. Sits between the ALU operand-select logic and the scalar adder.

## Interface
- `WIDTH`, default `` `LONG_WIDTH ``: lane width in bits, signed two's complement fixed point.
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `iInputReady`  in  1  request strobe; sampled only in IDLE.
- `iOperation`  in  1  0 = A+B, 1 = A−B; captured with the request.
- `iA`  in  3*WIDTH  operand vector; X = [WIDTH-1:0], Y next, Z top.
- `iB`  in  3*WIDTH  operand vector; same lane packing.
- `oBusy`  out  1  high from the accept edge until the done cycle, inclusive.
- `oR`  out  3*WIDTH  result vector; updated only at completion.
- `oOutputReady`  out  1  one-cycle done pulse.
- `oAddA`, `oAddB`  out  WIDTH each  lane operands to the adder.
- `oAddOperation`  out  1  operation to the adder.
- `oAddInputReady`  out  1  adder issue strobe.
- `iAddR`  in  WIDTH  adder result (combinational in the adder).
- `iAddOutputReady`  in  1  adder valid, one cycle after issue.

## Operation
- Operands and operation are registered on accept: IDLE with `iInputReady`=1.
- FSM states:
  - IDLE: accept request, go to ISSUE, lane=0.
  - ISSUE: `oAddInputReady`=1, lane operands driven; go to WAIT.
  - WAIT: operands held stable. On `iAddOutputReady`, capture `iAddR` into staging[lane].
    - If lane<2: lane+1, go to ISSUE.
    - Else: go to DONE.
  - DONE: `oR`<=staging, `oOutputReady`=1, go to IDLE.
- Lane counter is 2 bits and takes values 0..2 only; value 3 is unreachable and decodes to IDLE.
- `oAddA`/`oAddB`/`oAddOperation` are held through WAIT, because the adder result is combinational on held inputs.
- `iInputReady` outside IDLE is ignored. The request is not queued and no error is flagged.
- `iAddOutputReady` outside WAIT is ignored.
- If `iAddOutputReady` never arrives, the FSM stays in WAIT. There is no timeout.
- `oR` holds its last value until the next DONE.

## Timing
- Reset values: FSM=IDLE, lane=0, and all outputs 0, including `oR` and the staging register.
- Reset asserted mid-operation: immediate return to IDLE. The partial result is discarded and `oR` is cleared.
- Latency with a one-cycle adder: accept at edge 0; ISSUE cycles 1/3/5; WAIT cycles 2/4/6; `oOutputReady` high in cycle 7.
- Back-to-back: the next request is accepted in the cycle after DONE, giving an 8-cycle issue interval.
- `oBusy` falls in the cycle after DONE.

## Configuration
- `VECTOR_ADDSUB_SATURATE_EN` defined:
  - Each lane is checked for overflow on capture.
    - Add: overflow when sign(A)==sign(B) and sign(R)!=sign(A).
    - Sub: overflow when sign(A)!=sign(B) and sign(R)!=sign(A).
  - On overflow, the lane is clamped: positive overflow to 0x7F…F, negative overflow to 0x80…0.
- Undefined: results wrap modulo 2^WIDTH, identical to the raw adder output.

## Structure
- Shared package/defines: FSM state encodings (IDLE/ISSUE/WAIT/DONE), lane index constants, lane-slice width. `WIDTH` is derived from `` `LONG_WIDTH `` in `aDefinitions.v`.
- Sub-module: `addsub_lane_saturate`, a combinational overflow detect and clamp. It is instantiated once on the capture path and reduces to a passthrough when the macro is undefined.

## Test plan
- Reset then idle: `oR`=0, `oBusy`=0, `oOutputReady`=0. Assert `Reset`=0 mid-WAIT of lane Y → IDLE next edge, `oR`=0, no done pulse.
- Add: A=(1,2,3), B=(10,20,30), op=0 → `oOutputReady` in cycle 7, `oR`=(11,22,33). `oAddInputReady` is high exactly in cycles 1, 3 and 5.
- Subtract: A=(5,0,−1), B=(7,1,−1), op=1 → `oR`=(−2,−1,0).
- Request while busy: second `iInputReady` in cycle 3 is ignored. `oR` reflects the first request only, and a new request in cycle 8 is accepted.
- Overflow on X: A.X=0x7F…F, B.X=1, op=0 → X=0x7F…F with the macro, 0x80…0 without. Y and Z unaffected.
- Stalled adder: `iAddOutputReady` delayed 4 cycles on lane Z → FSM holds WAIT with operands stable. Done pulse arrives 4 cycles late and the result is correct.

Source files
------------

// File: rtl/vector_addsub_sequencer_pkg.sv
// vector_addsub_sequencer_pkg
//   Shared definitions for the vector add/sub sequencer: FSM state
//   encoding, lane indices and the default lane width.
//   `LONG_WIDTH normally comes from the project-wide definitions; the
//   fallback below keeps this slice self-contained.
//   Optional feature macro used by this slice: VECTOR_ADDSUB_SATURATE_EN.
`ifndef LONG_WIDTH
`define LONG_WIDTH 32
`endif

package vector_addsub_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int         NUM_LANES = 3;
  localparam logic [1:0] LANE_X    = 2'd0;
  localparam logic [1:0] LANE_Y    = 2'd1;
  localparam logic [1:0] LANE_Z    = 2'd2;
  localparam int         LANE_W    = `LONG_WIDTH;

endpackage

// File: rtl/vector_addsub_sequencer_saturate.sv
// addsub_lane_saturate
//   Combinational overflow detect and clamp on one adder lane result.
//   With VECTOR_ADDSUB_SATURATE_EN defined, a signed overflow clamps to
//   the most positive / most negative value; otherwise the raw adder
//   result passes straight through (modulo 2^WIDTH wrap).
//   Ports:
//     i_a, i_b : lane operands as presented to the adder
//     i_op     : 0 = add, 1 = subtract
//     i_r      : raw adder result
//     o_r      : lane result to stage
module addsub_lane_saturate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_r,
  output logic [WIDTH-1:0] o_r
);

`ifdef VECTOR_ADDSUB_SATURATE_EN
  logic w_sa, w_sb, w_sr, w_ovf;
  assign w_sa  = i_a[WIDTH-1];
  assign w_sb  = i_b[WIDTH-1];
  assign w_sr  = i_r[WIDTH-1];
  // Subtract flips B's effective sign, so the same-sign test inverts.
  assign w_ovf = (i_op ? (w_sa != w_sb) : (w_sa == w_sb)) && (w_sr != w_sa);
  // Overflow direction follows A's sign.
  assign o_r   = !w_ovf ? i_r :
                 w_sa   ? {1'b1, {(WIDTH-1){1'b0}}} :
                          {1'b0, {(WIDTH-1){1'b1}}};
`else
  logic w_unused;
  assign w_unused = ^{i_a, i_b, i_op};
  assign o_r      = i_r;
`endif

endmodule

// File: rtl/vector_addsub_sequencer.sv
// vector_addsub_sequencer
//   Serialises a three-lane (X, Y, Z) vector add/sub onto a scalar
//   fixed-point adder, stages the lane results and presents the vector
//   with a one-cycle done pulse.
//   Optional feature: VECTOR_ADDSUB_SATURATE_EN (per-lane clamp on overflow).
//   Ports:
//     Clock, Reset (async, active low)
//     iInputReady, iOperation, iA, iB : request (sampled in IDLE only)
//     oBusy, oR, oOutputReady         : status / assembled result
//     oAddA, oAddB, oAddOperation, oAddInputReady : to scalar adder
//     iAddR, iAddOutputReady          : from scalar adder
`ifndef LONG_WIDTH
`define LONG_WIDTH 32
`endif

module vector_addsub_sequencer
  import vector_addsub_sequencer_pkg::*;
#(
  parameter int WIDTH = `LONG_WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iInputReady,
  input  logic               iOperation,
  input  logic [3*WIDTH-1:0] iA,
  input  logic [3*WIDTH-1:0] iB,
  output logic               oBusy,
  output logic [3*WIDTH-1:0] oR,
  output logic               oOutputReady,
  output logic [WIDTH-1:0]   oAddA,
  output logic [WIDTH-1:0]   oAddB,
  output logic               oAddOperation,
  output logic               oAddInputReady,
  input  logic [WIDTH-1:0]   iAddR,
  input  logic               iAddOutputReady
);

  state_e                             r_state, w_next;
  logic [1:0]                         r_lane;
  logic                               r_op;
  logic [NUM_LANES-1:0][WIDTH-1:0]    r_a, r_b, r_stage, r_res;
  logic [WIDTH-1:0]                   w_lane_a, w_lane_b, w_lane_r;

  // Lane operand select; lane 3 never occurs and drives zero.
  always_comb begin
    w_lane_a = '0;
    w_lane_b = '0;
    case (r_lane)
      LANE_X:  begin w_lane_a = r_a[0]; w_lane_b = r_b[0]; end
      LANE_Y:  begin w_lane_a = r_a[1]; w_lane_b = r_b[1]; end
      LANE_Z:  begin w_lane_a = r_a[2]; w_lane_b = r_b[2]; end
      default: ;
    endcase
  end

  addsub_lane_saturate #(.WIDTH(WIDTH)) u_sat (
    .i_a  (w_lane_a),
    .i_b  (w_lane_b),
    .i_op (r_op),
    .i_r  (iAddR),
    .o_r  (w_lane_r)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (iInputReady) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:
        if (iAddOutputReady) begin
          case (r_lane)
            LANE_X, LANE_Y: w_next = S_ISSUE;
            LANE_Z:         w_next = S_DONE;
            default:        w_next = S_IDLE;
          endcase
        end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_lane  <= LANE_X;
      r_op    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_stage <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE:
          if (iInputReady) begin
            r_a    <= iA;
            r_b    <= iB;
            r_op   <= iOperation;
            r_lane <= LANE_X;
          end
        S_WAIT:
          if (iAddOutputReady) begin
            case (r_lane)
              LANE_X:  r_stage[0] <= w_lane_r;
              LANE_Y:  r_stage[1] <= w_lane_r;
              LANE_Z:  r_stage[2] <= w_lane_r;
              default: ;
            endcase
            if (r_lane < LANE_Z) r_lane <= r_lane + 2'd1;
          end
        S_DONE:  r_res <= r_stage;
        default: ;
      endcase
    end
  end

  assign oBusy          = (r_state != S_IDLE);
  assign oOutputReady   = (r_state == S_DONE);
  assign oR             = r_res;
  assign oAddA          = w_lane_a;
  assign oAddB          = w_lane_b;
  assign oAddOperation  = r_op;
  assign oAddInputReady = (r_state == S_ISSUE);

endmodule

// File: tb/tb_vector_addsub_sequencer.sv
// tb_vector_addsub_sequencer
//   Directed bench: behavioural scalar adder with a configurable stall on
//   lane Z, hand-computed vectors, cycle-accurate done / issue checks.
module tb_vector_addsub_sequencer;
  localparam int W = 32;

  logic           Clock = 1'b0;
  logic           Reset = 1'b0;
  logic           iInputReady = 1'b0;
  logic           iOperation = 1'b0;
  logic [3*W-1:0] iA = '0, iB = '0;
  logic           oBusy, oOutputReady, oAddOperation, oAddInputReady;
  logic [3*W-1:0] oR;
  logic [W-1:0]   oAddA, oAddB, iAddR;
  logic           iAddOutputReady;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_z = 0;

  vector_addsub_sequencer #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset),
    .iInputReady(iInputReady), .iOperation(iOperation), .iA(iA), .iB(iB),
    .oBusy(oBusy), .oR(oR), .oOutputReady(oOutputReady),
    .oAddA(oAddA), .oAddB(oAddB), .oAddOperation(oAddOperation),
    .oAddInputReady(oAddInputReady),
    .iAddR(iAddR), .iAddOutputReady(iAddOutputReady)
  );

  always #5 Clock = ~Clock;

  // Scalar adder model: combinational result, valid one cycle after
  // issue, plus stall_z extra cycles on the third issue of a vector.
  logic pend;
  int   cnt, iss_idx;
  assign iAddR           = oAddOperation ? (oAddA - oAddB) : (oAddA + oAddB);
  assign iAddOutputReady = pend && (cnt == 0);

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pend <= 1'b0; cnt <= 0; iss_idx <= 0;
    end else if (oAddInputReady) begin
      pend    <= 1'b1;
      cnt     <= (iss_idx == 2) ? stall_z : 0;
      iss_idx <= (iss_idx == 2) ? 0 : iss_idx + 1;
    end else if (iAddOutputReady) begin
      pend <= 1'b0;
    end else if (pend) begin
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3*W-1:0] vec(input logic [W-1:0] x, y, z);
    return {z, y, x};
  endfunction

  // Called at a negedge with the DUT idle; drives the request in this
  // cycle (cycle 0), runs to done, then checks the cycle after done.
  task automatic do_op(input string tag, input logic [3*W-1:0] a, b, input logic op,
                       input int stall, input int inj_cyc,
                       input logic [3*W-1:0] exp_r, input int exp_done);
    int          done_cyc;
    logic [15:0] iss;
    done_cyc = -1;
    iss      = '0;
    stall_z  = stall;
    iA = a; iB = b; iOperation = op; iInputReady = 1'b1;
    for (int c = 1; c < 40 && done_cyc < 0; c++) begin
      @(negedge Clock);
      // Scramble inputs after accept: results must come from the capture.
      iA = ~a; iB = ~b; iOperation = ~op;
      iInputReady = (c == inj_cyc);
      if (oAddInputReady && c < 16) iss[c] = 1'b1;
      chk({tag, "_busy"}, 128'(oBusy), 128'(1'b1));
      if (stall > 0 && c >= 6 && c <= 5 + stall) begin
        chk({tag, "_holdA"}, 128'(oAddA), 128'(a[3*W-1:2*W]));
        chk({tag, "_holdB"}, 128'(oAddB), 128'(b[3*W-1:2*W]));
      end
      if (oOutputReady) done_cyc = c;
    end
    iInputReady = 1'b0;
    chk({tag, "_done_cyc"}, 128'(done_cyc), 128'(exp_done));
    chk({tag, "_issue"}, 128'(iss), 128'(16'h002A));
    @(negedge Clock);
    chk({tag, "_oR"}, 128'(oR), 128'(exp_r));
    chk({tag, "_busy_after"}, 128'(oBusy), 128'(1'b0));
    chk({tag, "_done_after"}, 128'(oOutputReady), 128'(1'b0));
  endtask

  logic [W-1:0] sat_x, sat_y;
  int           pulses;

  initial begin
`ifdef VECTOR_ADDSUB_SATURATE_EN
    sat_x = 32'h7FFF_FFFF;
    sat_y = 32'h8000_0000;
`else
    sat_x = 32'h8000_0000;
    sat_y = 32'h7FFF_FFFF;
`endif
    repeat (2) @(negedge Clock);
    chk("rst_oR",   128'(oR),             128'(0));
    chk("rst_busy", 128'(oBusy),          128'(0));
    chk("rst_done", 128'(oOutputReady),   128'(0));
    chk("rst_iss",  128'(oAddInputReady), 128'(0));
    Reset = 1'b1;
    @(negedge Clock);
    chk("idle_busy", 128'(oBusy), 128'(0));

    do_op("add", vec(1, 2, 3), vec(10, 20, 30), 1'b0, 0, -1,
          vec(11, 22, 33), 7);
    // Back-to-back: accepted in the cycle after done; stray strobe in cycle 3.
    do_op("sub_busyreq", vec(5, 0, -1), vec(7, 1, -1), 1'b1, 0, 3,
          vec(-2, -1, 0), 7);
    do_op("ovf_x", vec(32'h7FFF_FFFF, 4, 100), vec(1, 5, -100), 1'b0, 0, -1,
          vec(sat_x, 9, 0), 7);
    do_op("ovf_y", vec(2, 32'h8000_0000, 0), vec(3, 1, 0), 1'b1, 0, -1,
          vec(-1, sat_y, 0), 7);
    do_op("stall", vec(100, 200, 300), vec(1, 2, 3), 1'b1, 4, -1,
          vec(99, 198, 297), 11);

    // Reset in lane Y's WAIT (cycle 4) after a completed vector.
    iA = vec(1, 2, 3); iB = vec(4, 5, 6); iOperation = 1'b0; iInputReady = 1'b1;
    stall_z = 0;
    @(negedge Clock);
    iInputReady = 1'b0;
    repeat (3) @(negedge Clock);
    chk("pre_rst_busy", 128'(oBusy), 128'(1));
    Reset = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(oBusy), 128'(0));
    chk("mid_rst_oR",   128'(oR),    128'(0));
    @(negedge Clock);
    Reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clock);
      if (oOutputReady || oBusy) pulses++;
    end
    chk("post_rst_quiet", 128'(pulses), 128'(0));
    chk("post_rst_oR",    128'(oR),     128'(0));

    do_op("add2", vec(-3, 7, 0), vec(3, -8, 1), 1'b0, 0, -1,
          vec(0, -1, 1), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
